multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with retired-instruction counter
module multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic        illegal,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_src,
   output logic [2:0]  aluc,
   output logic [3:0]  state,
   output logic [15:0] retired
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      EXEC_R   = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t cur;
   state_t nxt;
   logic   retire;
   logic   funct_ok;
   logic [2:0] funct_aluc;

   assign state = cur;

   always_comb begin
      funct_ok   = 1'b1;
      funct_aluc = 3'b010;
      case (funct)
         6'b100000: funct_aluc = 3'b010;
         6'b100010: funct_aluc = 3'b110;
         6'b100100: funct_aluc = 3'b000;
         6'b100101: funct_aluc = 3'b001;
         6'b101010: funct_aluc = 3'b111;
         default:   funct_ok   = 1'b0;
      endcase
   end

   always_comb begin
      nxt = FETCH;
      case (cur)
         FETCH:    nxt = mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:      nxt = EXEC_R;
               OP_LW, OP_SW:  nxt = MEM_ADDR;
               OP_BEQ:        nxt = BRANCH;
               OP_J:          nxt = JUMP;
               OP_ADDI:       nxt = ADDI_EX;
               default:       nxt = FETCH;
            endcase
         end
         MEM_ADDR: nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD:   nxt = mem_ready ? MEM_WB : MEM_RD;
         MEM_WB:   nxt = FETCH;
         MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
         EXEC_R:   nxt = funct_ok ? R_WB : FETCH;
         R_WB:     nxt = FETCH;
         BRANCH:   nxt = FETCH;
         JUMP:     nxt = FETCH;
         ADDI_EX:  nxt = ADDI_WB;
         ADDI_WB:  nxt = FETCH;
         default:  nxt = FETCH;
      endcase
   end

   // Illegal exits (DECODE/EXEC_R back to FETCH) never count as retirements.
   always_comb begin
      retire = 1'b0;
      case (cur)
         MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: retire = 1'b1;
         MEM_WR:  retire = mem_ready;
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur     <= FETCH;
         retired <= 16'h0000;
      end else begin
         cur <= nxt;
         if (retire)
            retired <= retired + 16'h0001;
      end
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      illegal    = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      aluc       = 3'b000;
      case (cur)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            aluc      = 3'b010;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            aluc      = 3'b010;
            case (opcode)
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
               default: illegal = 1'b1;
            endcase
         end
         MEM_ADDR, ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            aluc      = 3'b010;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            aluc      = funct_aluc;
            illegal   = ~funct_ok;
         end
         R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            aluc      = 3'b110;
            pc_src    = 2'b01;
            pc_write  = zero;
         end
         JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         ADDI_WB: reg_write = 1'b1;
         default: ;
      endcase
      // Reset forces every control output low, whatever the state register holds.
      if (reset) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_to_reg = 1'b0;
         reg_dst    = 1'b0;
         reg_write  = 1'b0;
         alu_src_a  = 1'b0;
         illegal    = 1'b0;
         alu_src_b  = 2'b00;
         pc_src     = 2'b00;
         aluc       = 3'b000;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg;
   logic        reg_dst, reg_write, alu_src_a, illegal;
   logic [1:0]  alu_src_b, pc_src;
   logic [2:0]  aluc;
   logic [3:0]  state;
   logic [15:0] retired;
   logic [16:0] ctrl;

   int checks = 0;
   int failures = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .illegal(illegal), .alu_src_b(alu_src_b), .pc_src(pc_src), .aluc(aluc),
      .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   assign ctrl = {pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, illegal, alu_src_b, pc_src, aluc};

   function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic io,
                                      input logic mr, input logic mw, input logic m2r,
                                      input logic rd, input logic rw, input logic asa,
                                      input logic ill, input logic [1:0] asb,
                                      input logic [1:0] pcs, input logic [2:0] al);
      return {pcw, irw, io, mr, mw, m2r, rd, rw, asa, ill, asb, pcs, al};
   endfunction

   task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #3;
   endtask

   logic [16:0] c_fetch, c_fetch_wait, c_decode, c_decode_ill, c_addr, c_memrd, c_memwb;
   logic [16:0] c_memwr, c_rsub, c_rbad, c_rwb, c_beq1, c_beq0, c_jump, c_addiwb;

   initial begin
      //                 pcw irw io mr mw m2r rd rw asa ill asb    pcs    aluc
      c_fetch      = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
      c_fetch_wait = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010);
      c_decode     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010);
      c_decode_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 3'b010);
      c_addr       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b010);
      c_memrd      = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
      c_memwb      = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000);
      c_memwr      = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000);
      c_rsub       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b110);
      c_rbad       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 3'b010);
      c_rwb        = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000);
      c_beq1       = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b110);
      c_beq0       = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 3'b110);
      c_jump       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000);
      c_addiwb     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000);

      reset = 1'b1; opcode = 6'b000000; funct = 6'b100010; zero = 1'b0; mem_ready = 1'b1;
      tick; tick;
      check("reset_ctrl", ctrl, 17'h0);
      check("reset_state", 17'(state), 17'd0);
      check("reset_retired", 17'(retired), 17'd0);
      reset = 1'b0; #1;
      check("fetch_first", ctrl, c_fetch);

      // R-type sub
      tick; check("r_decode_st", 17'(state), 17'd1); check("r_decode", ctrl, c_decode);
      tick; check("r_exec_st", 17'(state), 17'd6); check("r_exec_sub", ctrl, c_rsub);
      tick; check("r_wb_st", 17'(state), 17'd7); check("r_wb", ctrl, c_rwb);
      check("r_wb_ret", 17'(retired), 17'd0);
      tick; check("r_done_st", 17'(state), 17'd0); check("r_done_ret", 17'(retired), 17'd1);

      // Load with three wait cycles in MEM_RD
      opcode = 6'b100011;
      tick; check("lw_decode_st", 17'(state), 17'd1);
      tick; check("lw_addr_st", 17'(state), 17'd2); check("lw_addr", ctrl, c_addr);
      mem_ready = 1'b0;
      tick; check("lw_rd1_st", 17'(state), 17'd3); check("lw_rd1", ctrl, c_memrd);
      tick; check("lw_rd2_st", 17'(state), 17'd3);
      tick; check("lw_rd3_st", 17'(state), 17'd3);
      tick; check("lw_rd4_st", 17'(state), 17'd3);
      mem_ready = 1'b1;
      tick; check("lw_wb_st", 17'(state), 17'd4); check("lw_wb", ctrl, c_memwb);
      tick; check("lw_done_st", 17'(state), 17'd0); check("lw_done_ret", 17'(retired), 17'd2);

      // Branch taken then not taken
      opcode = 6'b000100; zero = 1'b1;
      tick; tick; check("beq1_st", 17'(state), 17'd8); check("beq1", ctrl, c_beq1);
      tick; check("beq1_ret", 17'(retired), 17'd3);
      zero = 1'b0;
      tick; tick; check("beq0", ctrl, c_beq0);
      tick; check("beq0_st", 17'(state), 17'd0); check("beq0_ret", 17'(retired), 17'd4);

      // Illegal opcode
      opcode = 6'b111111;
      tick; check("ill_op_decode", ctrl, c_decode_ill);
      tick; check("ill_op_st", 17'(state), 17'd0); check("ill_op_ret", 17'(retired), 17'd4);

      // Illegal funct
      opcode = 6'b000000; funct = 6'b000000;
      tick; tick; check("ill_fn_exec", ctrl, c_rbad);
      tick; check("ill_fn_st", 17'(state), 17'd0); check("ill_fn_fetch", ctrl, c_fetch);
      check("ill_fn_ret", 17'(retired), 17'd4);

      // ADDI and JUMP
      opcode = 6'b001000;
      tick; tick; check("addi_ex_st", 17'(state), 17'd10); check("addi_ex", ctrl, c_addr);
      tick; check("addi_wb_st", 17'(state), 17'd11); check("addi_wb", ctrl, c_addiwb);
      tick; check("addi_ret", 17'(retired), 17'd5);
      opcode = 6'b000010;
      tick; tick; check("jump_st", 17'(state), 17'd9); check("jump", ctrl, c_jump);
      tick; check("jump_ret", 17'(retired), 17'd6);

      // FETCH stall
      mem_ready = 1'b0; #1;
      check("fetch_wait", ctrl, c_fetch_wait);
      tick; check("fetch_hold_st", 17'(state), 17'd0);

      // Store wait interrupted by reset
      mem_ready = 1'b1; opcode = 6'b101011;
      tick; tick; check("sw_addr_st", 17'(state), 17'd2);
      mem_ready = 1'b0;
      tick; check("sw_wr_st", 17'(state), 17'd5); check("sw_wr", ctrl, c_memwr);
      tick; check("sw_hold_st", 17'(state), 17'd5);
      reset = 1'b1; #1;
      check("sw_reset_ctrl", ctrl, 17'h0);
      tick; check("sw_reset_st", 17'(state), 17'd0); check("sw_reset_ret", 17'(retired), 17'd0);
      reset = 1'b0; mem_ready = 1'b1;

      // Counter wrap via a JUMP retire from 0xFFFF
      dut.retired <= 16'hFFFF;
      opcode = 6'b000010;
      #1; check("wrap_preset", 17'(retired), 17'hFFFF);
      tick; tick; check("wrap_jump_st", 17'(state), 17'd9);
      tick; check("wrap_ret", 17'(retired), 17'h0000);

      // Store completing without wait retires
      opcode = 6'b101011;
      tick; tick; tick; check("sw2_wr_st", 17'(state), 17'd5);
      tick; check("sw2_done_st", 17'(state), 17'd0); check("sw2_ret", 17'(retired), 17'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
